// File: rtl/irq_entry_seq_if.sv
// Bus master interface used by the interrupt-entry sequencer: a simple
// request/ready byte bus with 24-bit addressing.
interface irq_entry_seq_if;
    logic [23:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [7:0]  bus_data_out;
    logic [7:0]  bus_data_in;
    logic        bus_ready;

    modport master (
        output bus_address,
        output bus_read,
        output bus_write,
        output bus_data_out,
        input  bus_data_in,
        input  bus_ready
    );

    modport slave (
        input  bus_address,
        input  bus_read,
        input  bus_write,
        input  bus_data_out,
        output bus_data_in,
        output bus_ready
    );
endinterface

// File: rtl/irq_entry_seq.sv
// S1C88 interrupt-entry sequencer. Accepts a request at an instruction
// boundary, acknowledges it, pushes CB/PCH/PCL/SC, fetches the vector word
// and hands the core its new PC/SP/SC with a single load strobe.
module irq_entry_seq #(
    parameter logic [23:0] VEC_BASE   = 24'h000000,
    parameter logic [7:0]  STACK_BANK = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  irq_req,
    input  logic                  irq_nmi,
    input  logic [1:0]            irq_priority,
    input  logic [4:0]            irq_vector,
    input  logic                  cpu_boundary,
    input  logic [15:0]           cpu_pc,
    input  logic [15:0]           cpu_sp,
    input  logic [7:0]            cpu_sc,
    input  logic [7:0]            cpu_cb,
    output logic                  irq_ack,
    output logic [4:0]            ack_vector,
    output logic                  busy,
    irq_entry_seq_if.master       bus,
    output logic                  load,
    output logic [15:0]           new_pc,
    output logic [15:0]           new_sp,
    output logic [7:0]            new_sc
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PUSH_CB  = 3'd1;
    localparam logic [2:0] S_PUSH_PCH = 3'd2;
    localparam logic [2:0] S_PUSH_PCL = 3'd3;
    localparam logic [2:0] S_PUSH_SC  = 3'd4;
    localparam logic [2:0] S_RD_VLO   = 3'd5;
    localparam logic [2:0] S_RD_VHI   = 3'd6;
    localparam logic [2:0] S_LOAD     = 3'd7;

    logic [2:0]  r_state;
    logic [4:0]  r_vec;
    logic [1:0]  r_prio;
    logic        r_nmi;
    logic [15:0] r_pc;
    logic [15:0] r_sp;
    logic [7:0]  r_sc;
    logic [7:0]  r_vlo;

    logic        r_ack;
    logic [4:0]  r_ack_vector;
    logic [23:0] r_addr;
    logic        r_rd;
    logic        r_wr;
    logic [7:0]  r_dout;
    logic        r_load;
    logic [15:0] r_new_pc;
    logic [15:0] r_new_sp;
    logic [7:0]  r_new_sc;

    logic        w_accept;
    logic [15:0] w_entry_sp;
    logic [15:0] w_sp_dec;
    logic [23:0] w_vec_addr;

    // Acceptance test and address arithmetic shared by the sequencer.
    // Stack pointer math is deliberately 16-bit so it wraps silently.
    always_comb begin
        w_accept   = cpu_boundary && irq_req &&
                     (irq_nmi || (irq_priority > cpu_sc[7:6]));
        w_entry_sp = cpu_sp - 16'd1;
        w_sp_dec   = r_sp - 16'd1;
        w_vec_addr = VEC_BASE + {18'd0, r_vec, 1'b0};
    end

    // Entry sequencer: every bus state holds its outputs until bus_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_vec        <= 5'd0;
            r_prio       <= 2'd0;
            r_nmi        <= 1'b0;
            r_pc         <= 16'd0;
            r_sp         <= 16'd0;
            r_sc         <= 8'd0;
            r_vlo        <= 8'd0;
            r_ack        <= 1'b0;
            r_ack_vector <= 5'd0;
            r_addr       <= 24'd0;
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_dout       <= 8'd0;
            r_load       <= 1'b0;
            r_new_pc     <= 16'd0;
            r_new_sp     <= 16'd0;
            r_new_sc     <= 8'd0;
        end else begin
            r_ack  <= 1'b0;
            r_load <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_vec        <= irq_vector;
                        r_prio       <= irq_priority;
                        r_nmi        <= irq_nmi;
                        r_pc         <= cpu_pc;
                        r_sc         <= cpu_sc;
                        r_sp         <= w_entry_sp;
                        r_addr       <= {STACK_BANK, w_entry_sp};
                        r_dout       <= cpu_cb;
                        r_wr         <= 1'b1;
                        r_ack        <= 1'b1;
                        r_ack_vector <= irq_vector;
                        r_state      <= S_PUSH_CB;
                    end
                end
                S_PUSH_CB: begin
                    if (bus.bus_ready) begin
                        r_sp    <= w_sp_dec;
                        r_addr  <= {STACK_BANK, w_sp_dec};
                        r_dout  <= r_pc[15:8];
                        r_state <= S_PUSH_PCH;
                    end
                end
                S_PUSH_PCH: begin
                    if (bus.bus_ready) begin
                        r_sp    <= w_sp_dec;
                        r_addr  <= {STACK_BANK, w_sp_dec};
                        r_dout  <= r_pc[7:0];
                        r_state <= S_PUSH_PCL;
                    end
                end
                S_PUSH_PCL: begin
                    if (bus.bus_ready) begin
                        r_sp    <= w_sp_dec;
                        r_addr  <= {STACK_BANK, w_sp_dec};
                        r_dout  <= r_sc;
                        r_state <= S_PUSH_SC;
                    end
                end
                S_PUSH_SC: begin
                    if (bus.bus_ready) begin
                        r_wr    <= 1'b0;
                        r_rd    <= 1'b1;
                        r_addr  <= w_vec_addr;
                        r_state <= S_RD_VLO;
                    end
                end
                S_RD_VLO: begin
                    if (bus.bus_ready) begin
                        r_vlo   <= bus.bus_data_in;
                        r_addr  <= w_vec_addr + 24'd1;
                        r_state <= S_RD_VHI;
                    end
                end
                S_RD_VHI: begin
                    if (bus.bus_ready) begin
                        r_rd     <= 1'b0;
                        r_load   <= 1'b1;
                        r_new_pc <= {bus.bus_data_in, r_vlo};
                        // Working SP already sits at entry SP minus four.
                        r_new_sp <= r_sp;
                        r_new_sc <= {(r_nmi ? 2'b11 : r_prio), r_sc[5:0]};
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_rd    <= 1'b0;
                    r_wr    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign irq_ack          = r_ack;
    assign ack_vector       = r_ack_vector;
    assign busy             = (r_state != S_IDLE);
    assign bus.bus_address  = r_addr;
    assign bus.bus_read     = r_rd;
    assign bus.bus_write    = r_wr;
    assign bus.bus_data_out = r_dout;
    assign load             = r_load;
    assign new_pc           = r_new_pc;
    assign new_sp           = r_new_sp;
    assign new_sc           = r_new_sc;

endmodule
